// File: rtl/soml_frame_loader.sv
// Frame loader between the UART front end and the SOML decoder: captures one
// frame of H (16) and Y (8) complex words, serves decoder reads, hands the result back.
module soml_frame_loader #(
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] H_re_out,
    input  logic [31:0] H_im_out,
    input  logic        H_out,
    input  logic [31:0] Y_re_out,
    input  logic [31:0] Y_im_out,
    input  logic        Y_out,
    input  logic        rd_req,
    input  logic        rd_sel,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_re,
    output logic [31:0] rd_im,
    output logic        rd_valid,
    input  logic        result_valid,
    input  logic [11:0] result,
    output logic        start_12bit,
    output logic [11:0] val_12bit_to_send,
    output logic        frame_ready,
    output logic        err_overflow,
    output logic        err_timeout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2, DONE = 2'd3} state_t;

    localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LOAD_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [4:0]    h_cnt_q, h_cnt_d;
    logic [3:0]    y_cnt_q, y_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovf_q, ovf_d;
    logic          tmo_err_q, tmo_err_d;
    logic          start12_q, start12_d;
    logic [11:0]   val_q, val_d;
    logic          ready_q, ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_re_q, rd_im_q;
    logic          h_we, y_we, frame_full, do_restart;
    logic [63:0]   rd_word;

    // Frame storage is deliberately left out of reset so it maps onto plain registers/RAM.
    logic [63:0] h_bank [16];
    logic [63:0] y_bank [8];

    assign frame_full = (h_cnt_q == 5'd16) && (y_cnt_q == 4'd8);
    // DONE always returns to IDLE, so a start seen there is not treated as a restart.
    assign do_restart = start && (state_q != DONE);

    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        y_cnt_d   = y_cnt_q;
        tmo_d     = tmo_q;
        ovf_d     = ovf_q;
        tmo_err_d = tmo_err_q;
        start12_d = start12_q;
        val_d     = val_q;
        ready_d   = ready_q;
        h_we      = 1'b0;
        y_we      = 1'b0;
        if (do_restart) begin
            state_d   = LOAD;
            h_cnt_d   = '0;
            y_cnt_d   = '0;
            tmo_d     = '0;
            ovf_d     = 1'b0;
            tmo_err_d = 1'b0;
            start12_d = 1'b1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (H_out) begin
                        if (h_cnt_q == 5'd16) begin
                            ovf_d = 1'b1;
                        end else begin
                            h_we    = 1'b1;
                            h_cnt_d = h_cnt_q + 5'd1;
                        end
                    end
                    if (Y_out) begin
                        if (y_cnt_q == 4'd8) begin
                            ovf_d = 1'b1;
                        end else begin
                            y_we    = 1'b1;
                            y_cnt_d = y_cnt_q + 4'd1;
                        end
                    end
                    if (frame_full) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d   = IDLE;
                        tmo_err_d = 1'b1;
                        start12_d = 1'b0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                READY: begin
                    if (result_valid) begin
                        val_d     = result;
                        start12_d = 1'b0;
                        state_d   = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign rd_valid_d = rd_req && (state_q == READY);
    assign rd_word    = rd_sel ? (rd_addr[3] ? 64'd0 : y_bank[rd_addr[2:0]]) : h_bank[rd_addr];

    always_ff @(posedge CLOCK_50) begin
        if (h_we) h_bank[h_cnt_q[3:0]] <= {H_re_out, H_im_out};
        if (y_we) y_bank[y_cnt_q[2:0]] <= {Y_re_out, Y_im_out};
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            h_cnt_q    <= '0;
            y_cnt_q    <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            start12_q  <= 1'b0;
            val_q      <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_re_q    <= '0;
            rd_im_q    <= '0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            y_cnt_q    <= y_cnt_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            tmo_err_q  <= tmo_err_d;
            start12_q  <= start12_d;
            val_q      <= val_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            if (rd_valid_d) begin
                rd_re_q <= rd_word[63:32];
                rd_im_q <= rd_word[31:0];
            end
        end
    end

    assign rd_re             = rd_re_q;
    assign rd_im             = rd_im_q;
    assign rd_valid          = rd_valid_q;
    assign start_12bit       = start12_q;
    assign val_12bit_to_send = val_q;
    assign frame_ready       = ready_q;
    assign err_overflow      = ovf_q;
    assign err_timeout       = tmo_err_q;
    assign state_dbg         = state_q;

endmodule

// File: doc/soml_frame_loader.md
SOML_FRAME_LOADER -- requirements
Module: soml_frame_loader

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 64, max cycles from start to full frame capture.
REQ-002 SHALL have port CLOCK_50 input 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start input 1: one-cycle frame-begin pulse from UART front end.
REQ-005 SHALL have ports H_re_out, H_im_out input 32 each, plus H_out input 1: H element data and its valid pulse.
REQ-006 SHALL have ports Y_re_out, Y_im_out input 32 each, plus Y_out input 1: Y element data and its valid pulse.
REQ-007 SHALL have ports rd_req input 1, rd_sel input 1 (0=H, 1=Y), rd_addr input 4: decoder read request.
REQ-008 SHALL have ports rd_re, rd_im output 32 each, plus rd_valid output 1: read data and its valid flag.
REQ-009 SHALL have ports result_valid input 1 and result input 12: decoder result pulse and value.
REQ-010 SHALL have ports start_12bit output 1 (high = result pending) and val_12bit_to_send output 12: result handoff to UART.
REQ-011 SHALL have ports frame_ready output 1, err_overflow output 1, err_timeout output 1 and state_dbg output 2.

Function
REQ-012 SHALL implement states IDLE=0, LOAD=1, READY=2 and DONE=3; state_dbg SHALL equal the current state.
REQ-013 IDLE: on start SHALL go to LOAD, clear the H/Y counters, timeout counter and both error flags, and set start_12bit=1.
REQ-014 LOAD: each H_out pulse SHALL write {H_re_out,H_im_out} to H bank[h_cnt] and increment h_cnt (0..16); Y_out likewise to Y bank[y_cnt] (0..8); H and Y SHALL be captured independently in the same cycle.
REQ-015 LOAD: an H_out pulse with h_cnt==16, or a Y_out pulse with y_cnt==8, SHALL be discarded and SHALL set err_overflow (sticky until the next start).
REQ-016 LOAD: when h_cnt==16 and y_cnt==8, SHALL go to READY in the following cycle and assert frame_ready=1 (level).
REQ-017 LOAD: when the timeout counter reaches LOAD_TIMEOUT-1 without completion, SHALL set err_timeout, clear start_12bit, and go to IDLE.
REQ-018 READY: on rd_req, SHALL present the selected bank entry on rd_re/rd_im with rd_valid=1 exactly one cycle later; read latency 1, one read per cycle; rd_sel=1 with rd_addr>7 SHALL return 0 with rd_valid=1.
REQ-019 rd_req outside READY SHALL be ignored (rd_valid stays 0).
REQ-020 READY: on result_valid, SHALL register val_12bit_to_send<=result, drive start_12bit<=0 in the same edge, and go to DONE.
REQ-021 DONE: val_12bit_to_send and the banks SHALL hold; frame_ready SHALL stay 1; go to IDLE next cycle.
REQ-022 start in LOAD or READY SHALL abort and restart as in REQ-013 (frame_ready<=0); result_valid and start in the same cycle: start wins, result dropped.
REQ-023 result_valid outside READY SHALL be ignored; val_12bit_to_send SHALL change only per REQ-020.
REQ-024 Banks are plain registers, not reset; contents after reset are don't-care until written.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counters=0, start_12bit=0, val_12bit_to_send=0, rd_re=rd_im=0, rd_valid=0, frame_ready=0, err_overflow=0, err_timeout=0.
REQ-026 Reset mid-LOAD or mid-READY SHALL discard the frame; the first start after release SHALL begin a clean load.

Verification
REQ-027 Normal: start, then 16 H pulses (H_re=k, H_im=100+k) parallel with 8 Y pulses (Y_re=200+k) -> frame_ready=1; rd H addr 5 -> next cycle rd_re=5, rd_im=105; rd Y addr 7 -> rd_re=207.
REQ-028 Result: in READY, result_valid with result=12'hA5C -> same edge val_12bit_to_send=0xA5C, start_12bit 1->0, state DONE then IDLE.
REQ-029 Overflow: 17 H pulses in LOAD -> err_overflow=1, H bank[0..15] unchanged by the 17th.
REQ-030 Timeout: start, only 10 H pulses -> cycle 63 after start: err_timeout=1, start_12bit=0, state IDLE.
REQ-031 Restart/reset: start during READY -> frame_ready=0, counters 0, start_12bit=1; rst_n low mid-LOAD -> all outputs at REQ-025 values asynchronously.
